// File: rtl/pipe_ctrl_hazard_pkg.sv
// pipe_ctrl_pkg: shared opcodes, forward encodings and stage bundles for the RV32I control path
// Contents: opcode constants, forward-select encodings, ctrl_t decode bundle,
//           ex_t ID/EX register contents, fwd_sel helper.
package pipe_ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;
    localparam ctrl_t BUBBLE = '0;
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic [2:0] funct3;
        logic       funct7b5;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ex_t;
    // EX/MEM has priority over MEM/WB; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(logic [4:0] rs, logic rw_m, logic [4:0] rd_m,
                                           logic rw_w, logic [4:0] rd_w);
        return (rw_m && |rd_m && rd_m == rs) ? FWD_MEM :
               (rw_w && |rd_w && rd_w == rs) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// pipe_ctrl_hazard_if: bundle between the datapath and the control/hazard sequencer
// master: datapath side (drives InstrD, ZeroE, MemReadyM; receives controls)
// slave:  sequencer side (pipe_ctrl_hazard)
interface pipe_ctrl_hazard_if;
    logic [31:0] InstrD;
    logic        ZeroE;
    logic        MemReadyM;
    logic [1:0]  ImmSrcD;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemWriteM, ResultSrcW, ALUSrcE;
    logic [1:0]  ALUOpE;
    logic [2:0]  Funct3E;
    logic        Funct7b5E, PCSrcE;
    logic        StallF, StallD, FlushD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    modport master (
        output InstrD, ZeroE, MemReadyM,
        input  ImmSrcD, RegWriteE, RegWriteM, RegWriteW, MemWriteM, ResultSrcW, ALUSrcE,
               ALUOpE, Funct3E, Funct7b5E, PCSrcE, StallF, StallD, FlushD,
               ForwardAE, ForwardBE, MemErr
    );
    modport slave (
        input  InstrD, ZeroE, MemReadyM,
        output ImmSrcD, RegWriteE, RegWriteM, RegWriteW, MemWriteM, ResultSrcW, ALUSrcE,
               ALUOpE, Funct3E, Funct7b5E, PCSrcE, StallF, StallD, FlushD,
               ForwardAE, ForwardBE, MemErr
    );
endinterface

// File: rtl/pipe_ctrl_hazard_hazard.sv
// hazard_unit: combinational memory-stall, branch, load-use and forwarding decisions
// In:  ID source regs + operand usage, EX/MEM/WB stage fields, ZeroE, MemReadyM
// Out: mem_stall, pc_src (also FlushD), stall (StallF/StallD), flush_e (ID/EX bubble), fwd_a/fwd_b
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       result_src_e,
    input  logic       branch_e,
    input  logic       zero_e,
    input  logic       reg_write_m,
    input  logic       mem_write_m,
    input  logic       result_src_m,
    input  logic       mem_ready_m,
    input  logic [4:0] rd_m,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    output logic       mem_stall,
    output logic       pc_src,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);
    logic load_use;
    always_comb begin
        mem_stall = (mem_write_m | result_src_m) & ~mem_ready_m;
        load_use  = result_src_e & |rd_e & ((uses_rs1 & rd_e == rs1_d) | (uses_rs2 & rd_e == rs2_d));
        // a frozen pipeline must not redirect; the branch resolves once memory releases
        pc_src    = ~mem_stall & branch_e & zero_e;
        stall     = mem_stall | (~pc_src & load_use);
        flush_e   = ~mem_stall & (pc_src | load_use);
        fwd_a     = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
        fwd_b     = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    end
endmodule

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: RV32I 5-stage control path with decode, stage control registers and hazards
// clk, rst: pipeline clock, asynchronous active-high reset
// bus (slave): InstrD/ZeroE/MemReadyM in; decode, per-stage controls, stall/flush/forward, MemErr out
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic              clk,
    input logic              rst,
    pipe_ctrl_hazard_if.slave bus
);
    ctrl_t            ctrl_d;
    logic             uses_rs1, uses_rs2;
    logic [6:0]       op;
    ex_t              ex_d, ex;
    logic             reg_write_m, mem_write_m, result_src_m;
    logic [4:0]       rd_m;
    logic             reg_write_w, result_src_w;
    logic [4:0]       rd_w;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_err;
    logic             mem_stall, pc_src, stall, flush_e;
    logic [1:0]       fwd_a, fwd_b;
    logic             unused_instr;
    assign op           = bus.InstrD[6:0];
    assign unused_instr = ^{bus.InstrD[31], bus.InstrD[29:25]};
    always_comb begin
        ctrl_d = BUBBLE;
        case (op)
            OP_LOAD:   ctrl_d = ctrl_t'(9'b1_00_1_0_1_0_00);
            OP_STORE:  ctrl_d = ctrl_t'(9'b0_01_1_1_0_0_00);
            OP_R:      ctrl_d = ctrl_t'(9'b1_00_0_0_0_0_10);
            OP_BRANCH: ctrl_d = ctrl_t'(9'b0_10_0_0_0_1_01);
            OP_IALU:   ctrl_d = ctrl_t'(9'b1_00_1_0_0_0_00);
            default:   ctrl_d = BUBBLE;
        endcase
        uses_rs1 = op inside {OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_IALU};
        uses_rs2 = op inside {OP_STORE, OP_R, OP_BRANCH};
        ex_d = '{ctrl_d.reg_write, ctrl_d.alu_src, ctrl_d.mem_write, ctrl_d.result_src,
                 ctrl_d.branch, ctrl_d.alu_op, bus.InstrD[14:12], bus.InstrD[30],
                 bus.InstrD[19:15], bus.InstrD[24:20], bus.InstrD[11:7]};
        cnt_nxt = mem_stall ? ((&cnt) ? cnt : cnt + 1'b1) : '0;
    end
    hazard_unit u_hazard (
        .rs1_d(bus.InstrD[19:15]), .rs2_d(bus.InstrD[24:20]),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .rs1_e(ex.rs1), .rs2_e(ex.rs2), .rd_e(ex.rd),
        .result_src_e(ex.result_src), .branch_e(ex.branch), .zero_e(bus.ZeroE),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .mem_ready_m(bus.MemReadyM), .rd_m(rd_m),
        .reg_write_w(reg_write_w), .rd_w(rd_w),
        .mem_stall(mem_stall), .pc_src(pc_src), .stall(stall), .flush_e(flush_e),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );
    // flush_e already implies no memory stall, so a stall simply holds ID/EX
    always_ff @(posedge clk or posedge rst)
        if (rst) ex <= '0;
        else if (!mem_stall) ex <= flush_e ? '0 : ex_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) {reg_write_m, mem_write_m, result_src_m, rd_m} <= '0;
        else if (!mem_stall) {reg_write_m, mem_write_m, result_src_m, rd_m} <= {ex.reg_write, ex.mem_write, ex.result_src, ex.rd};
    // MEM/WB takes a bubble each stall cycle so the held M instruction retires only once
    always_ff @(posedge clk or posedge rst)
        if (rst) {reg_write_w, result_src_w, rd_w} <= '0;
        else {reg_write_w, result_src_w, rd_w} <= mem_stall ? 7'b0 : {reg_write_m, result_src_m, rd_m};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            mem_err <= mem_err | (cnt_nxt >= CNT_W'(MEM_TIMEOUT));
        end
    assign bus.ImmSrcD    = ctrl_d.imm_src;
    assign bus.RegWriteE  = ex.reg_write;
    assign bus.RegWriteM  = reg_write_m;
    assign bus.RegWriteW  = reg_write_w;
    assign bus.MemWriteM  = mem_write_m;
    assign bus.ResultSrcW = result_src_w;
    assign bus.ALUSrcE    = ex.alu_src;
    assign bus.ALUOpE     = ex.alu_op;
    assign bus.Funct3E    = ex.funct3;
    assign bus.Funct7b5E  = ex.funct7b5;
    assign bus.PCSrcE     = pc_src;
    assign bus.StallF     = stall;
    assign bus.StallD     = stall;
    assign bus.FlushD     = pc_src;
    assign bus.ForwardAE  = fwd_a;
    assign bus.ForwardBE  = fwd_b;
    assign bus.MemErr     = mem_err;
endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb_pipe_ctrl_hazard: table-driven and randomized checks of pipe_ctrl_hazard against an instruction-level model
module tb_pipe_ctrl_hazard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pipe_ctrl_hazard_if bus();
    pipe_ctrl_hazard #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic        r;
        logic        st;
        logic        pc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        rww;
        logic        err;
    } vec_t;
    vec_t tv[64];
    int   nv = 0;
    // model: whole instruction words sitting in EX, MEM and WB
    logic [31:0] me, mm, mwb;
    int          mcnt;
    logic        merr;
    logic        last_stall, last_flush;
    logic [31:0] LW5, ADD652, ADD602, ADD312, SUB433, ADD012, SUB400, BEQ, ADD712, SW, ADD812, LW9;
    localparam logic [31:0] NOP = 32'h0;
    function automatic logic [31:0] r_op(int f7b5, int rs2, int rs1, int rd);
        return {1'b0, f7b5[0], 5'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] lw_op(int rd, int rs1);
        return {12'b0, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
    endfunction
    function automatic logic [31:0] sw_op(int rs2, int rs1, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] beq_op(int rs1, int rs2);
        return {7'b0, rs2[4:0], rs1[4:0], 3'b000, 5'b0, 7'b1100011};
    endfunction
    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp} straight from the decode table
    function automatic logic [8:0] bnd(logic [31:0] i);
        case (i[6:0])
            7'b0000011: return 9'b1_00_1_0_1_0_00;
            7'b0100011: return 9'b0_01_1_1_0_0_00;
            7'b0110011: return 9'b1_00_0_0_0_0_10;
            7'b1100011: return 9'b0_10_0_0_0_1_01;
            7'b0010011: return 9'b1_00_1_0_0_0_00;
            default:    return 9'b0;
        endcase
    endfunction
    function automatic logic [1:0] fsel(logic [4:0] rs);
        logic [8:0] bm, bw;
        bm = bnd(mm);
        bw = bnd(mwb);
        if (bm[8] && mm[11:7] != 5'd0 && mm[11:7] == rs) return 2'b10;
        if (bw[8] && mwb[11:7] != 5'd0 && mwb[11:7] == rs) return 2'b01;
        return 2'b00;
    endfunction
    function automatic logic [22:0] dut_pack();
        return {bus.ImmSrcD, bus.RegWriteE, bus.RegWriteM, bus.RegWriteW, bus.MemWriteM,
                bus.ResultSrcW, bus.ALUSrcE, bus.ALUOpE, bus.Funct3E, bus.Funct7b5E, bus.PCSrcE,
                bus.StallF, bus.StallD, bus.FlushD, bus.ForwardAE, bus.ForwardBE, bus.MemErr};
    endfunction
    task automatic model_reset();
        me = '0; mm = '0; mwb = '0; mcnt = 0; merr = 1'b0;
    endtask
    task automatic model_out(input logic [31:0] id, input logic z, input logic r,
                             output logic [22:0] o, output logic st, output logic fl,
                             output logic ms, output logic bub);
        logic [8:0] bd, be, bm, bw;
        logic       tk, lu, u1, u2;
        bd = bnd(id); be = bnd(me); bm = bnd(mm); bw = bnd(mwb);
        u1 = id[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011};
        u2 = id[6:0] inside {7'b0100011, 7'b0110011, 7'b1100011};
        ms = (bm[4] | bm[3]) & ~r;
        tk = !ms && be[2] && z;
        lu = be[3] && me[11:7] != 5'd0 &&
             ((u1 && me[11:7] == id[19:15]) || (u2 && me[11:7] == id[24:20]));
        st  = ms || (lu && !tk);
        fl  = tk;
        bub = tk || lu;
        o = {bd[7:6], be[8], bm[8], bw[8], bm[4], bw[3], be[5], be[1:0], me[14:12], me[30],
             tk, st, st, tk, fsel(me[19:15]), fsel(me[24:20]), merr};
    endtask
    task automatic model_adv(input logic [31:0] id, input logic ms, input logic bub);
        if (ms) begin
            mwb = '0;
            if (mcnt < 31) mcnt++;
            if (mcnt >= 16) merr = 1'b1;
        end else begin
            mcnt = 0;
            mwb = mm;
            mm = me;
            me = bub ? 32'h0 : id;
        end
    endtask
    task automatic check(input string nm, input logic [22:0] act, input logic [22:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic vec_t mk(logic [31:0] i, int z, int r, int st, int pc, int fa, int fb, int rww, int err);
        vec_t v;
        v.instr = i; v.z = z[0]; v.r = r[0]; v.st = st[0]; v.pc = pc[0];
        v.fa = fa[1:0]; v.fb = fb[1:0]; v.rww = rww[0]; v.err = err[0];
        return v;
    endfunction
    task automatic add(input logic [31:0] i, input int z, input int r, input int st, input int pc,
                       input int fa, input int fb, input int rww, input int err);
        tv[nv] = mk(i, z, r, st, pc, fa, fb, rww, err);
        nv++;
    endtask
    task automatic step(input vec_t v, input bit hand, input string nm);
        logic [22:0] eo;
        logic        st, fl, ms, bub;
        @(negedge clk);
        bus.InstrD = v.instr; bus.ZeroE = v.z; bus.MemReadyM = v.r;
        #1;
        model_out(v.instr, v.z, v.r, eo, st, fl, ms, bub);
        check("model", dut_pack(), eo);
        if (hand)
            check(nm, {12'b0, bus.StallF, bus.StallD, bus.PCSrcE, bus.FlushD, bus.ForwardAE, bus.ForwardBE, bus.RegWriteW, bus.MemErr},
                      {12'b0, v.st, v.st, v.pc, v.pc, v.fa, v.fb, v.rww, v.err});
        last_stall = st;
        last_flush = fl;
        @(posedge clk);
        model_adv(v.instr, ms, bub);
    endtask
    task automatic reset_pulse();
        logic [22:0] eo;
        logic        st, fl, ms, bub;
        @(negedge clk);
        #3 rst = 1'b1;
        #1 model_reset();
        model_out(bus.InstrD, bus.ZeroE, bus.MemReadyM, eo, st, fl, ms, bub);
        check("async_rst", dut_pack(), eo);
        @(negedge clk);
        rst = 1'b0; bus.InstrD = '0; bus.ZeroE = 1'b0; bus.MemReadyM = 1'b1;
    endtask
    initial begin
        logic [31:0] cur;
        int          off;
        LW5 = lw_op(5, 1);         ADD652 = r_op(0, 2, 5, 6); ADD602 = r_op(0, 2, 0, 6);
        ADD312 = r_op(0, 2, 1, 3); SUB433 = r_op(1, 3, 3, 4); ADD012 = r_op(0, 2, 1, 0);
        SUB400 = r_op(1, 0, 0, 4); BEQ = beq_op(1, 2);        ADD712 = r_op(0, 2, 1, 7);
        SW = sw_op(2, 1, 4);       ADD812 = r_op(0, 2, 1, 8); LW9 = lw_op(9, 1);
        // instr, ZeroE, MemReadyM | stall, pcsrc/flush, fwdA, fwdB, RegWriteW, MemErr
        add(LW5, 0, 1, 0, 0, 0, 0, 0, 0);
        add(ADD652, 0, 1, 1, 0, 0, 0, 0, 0);
        add(ADD652, 0, 1, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 1, 0, 1, 0);
        add(LW5, 0, 1, 0, 0, 0, 0, 0, 0);
        add(ADD602, 0, 1, 0, 0, 0, 0, 1, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 0);
        add(ADD312, 0, 1, 0, 0, 0, 0, 1, 0);
        add(SUB433, 0, 1, 0, 0, 0, 0, 1, 0);
        add(NOP, 0, 1, 0, 0, 2, 2, 0, 0);
        add(ADD312, 0, 1, 0, 0, 0, 0, 1, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 1, 0);
        add(SUB433, 0, 1, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 1, 1, 1, 0);
        add(ADD012, 0, 1, 0, 0, 0, 0, 0, 0);
        add(SUB400, 0, 1, 0, 0, 0, 0, 1, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 0);
        add(BEQ, 0, 1, 0, 0, 0, 0, 1, 0);
        add(ADD712, 1, 1, 0, 1, 0, 0, 1, 0);
        add(NOP, 1, 1, 0, 0, 0, 0, 0, 0);
        add(BEQ, 0, 1, 0, 0, 0, 0, 0, 0);
        add(ADD712, 0, 1, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 0);
        add(SW, 0, 1, 0, 0, 0, 0, 0, 0);
        add(BEQ, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(ADD812, 1, 0, 1, 0, 0, 0, 0, 0);
        add(ADD812, 1, 1, 0, 1, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 0);
        add(LW9, 0, 1, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) add(NOP, 0, 0, 1, 0, 0, 0, 0, 0);
        add(NOP, 0, 1, 0, 0, 0, 0, 0, 1);
        add(NOP, 0, 1, 0, 0, 0, 0, 1, 1);
        bus.InstrD = '0; bus.ZeroE = 1'b0; bus.MemReadyM = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", dut_pack(), 23'd0);
        rst = 1'b0;
        for (int k = 0; k < nv; k++) step(tv[k], 1'b1, $sformatf("vec%0d", k));
        step(mk(BEQ, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "");
        @(negedge clk);
        bus.InstrD = ADD712; bus.ZeroE = 1'b1; bus.MemReadyM = 1'b1;
        #1 check("pre_rst_pcsrc", {22'b0, bus.PCSrcE}, 23'd1);
        #2 rst = 1'b1;
        #1 model_reset();
        check("rst_all_zero", dut_pack(), 23'd0);
        @(negedge clk);
        rst = 1'b0; bus.InstrD = '0; bus.ZeroE = 1'b0;
        step(mk(ADD312, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, "post_rst_add");
        step(mk(NOP, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, "post_rst_nop");
        cur = '0;
        off = 0;
        last_stall = 1'b0;
        last_flush = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            logic [6:0]  ops[6];
            logic        r;
            if ($urandom_range(0, 299) == 0) reset_pulse();
            ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b0000000};
            if (last_stall) w = cur;
            else if (last_flush) w = '0;
            else begin
                w = $urandom;
                w[6:0]   = ops[$urandom_range(0, 5)];
                w[11:7]  = 5'($urandom_range(0, 3));
                w[19:15] = 5'($urandom_range(0, 3));
                w[24:20] = 5'($urandom_range(0, 3));
            end
            cur = w;
            if (off == 0 && $urandom_range(0, 63) == 0) off = $urandom_range(10, 20);
            r = (off > 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
            if (off > 0) off--;
            step(mk(w, int'($urandom_range(0, 1)), int'(r), 0, 0, 0, 0, 0, 0), 1'b0, "");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
